// File: rtl/ym3438_timer_pkg.sv
// Shared constants and types for the OPN2 Timer A / Timer B unit.
package ym3438_timer_pkg;

  // Bit positions inside the reg 0x27 image.
  localparam int CTRL_LOAD_A  = 0;
  localparam int CTRL_LOAD_B  = 1;
  localparam int CTRL_EN_A    = 2;
  localparam int CTRL_EN_B    = 3;
  localparam int CTRL_RST_A   = 4;
  localparam int CTRL_RST_B   = 5;
  localparam int CTRL_MODE_LO = 6;
  localparam int CTRL_MODE_HI = 7;

  // Channel-3 mode field; any value with bit 0 set is the 3-channel mode.
  typedef enum logic [1:0] {
    MODE_NORMAL  = 2'b00,
    MODE_3CH     = 2'b01,
    MODE_CSM     = 2'b10,
    MODE_3CH_ALT = 2'b11
  } mode_e;

  // True when the mode field selects composite sine mode.
  function automatic logic is_csm(input logic [1:0] mode);
    return (mode == MODE_CSM);
  endfunction

endpackage

// File: rtl/ym3438_timer_counter.sv
// One up-counting timer: reload register, LOAD edge detect, overflow strobe.
// All state moves only on a commit; ovf is a same-cycle strobe for the parent.
module ym3438_timer_counter #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit,
  input  logic             tick,
  input  logic             load_wr,
  input  logic             load_in,
  input  logic             val_wr,
  input  logic [WIDTH-1:0] val,
  output logic [WIDTH-1:0] cnt,
  output logic             ovf
);

  logic [WIDTH-1:0] reload_q, reload_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             load_q, load_d;
  logic             ovf_d;

  // Next-state: load edge reloads (old reload value), tick increments or wraps.
  always_comb begin
    reload_d = reload_q;
    cnt_d    = cnt_q;
    load_d   = load_q;
    ovf_d    = 1'b0;
    if (commit) begin
      if (load_wr) begin
        load_d = load_in;
      end else begin
        load_d = load_q;
      end
      if (val_wr) begin
        reload_d = val;
      end else begin
        reload_d = reload_q;
      end
      if (load_d && !load_q) begin
        cnt_d = reload_q;
      end else if (load_d && tick) begin
        if (&cnt_q) begin
          ovf_d = 1'b1;
          cnt_d = reload_q;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      load_d = load_q;
    end
  end

  // Counter state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      reload_q <= '0;
      cnt_q    <= '0;
      load_q   <= 1'b0;
    end else begin
      reload_q <= reload_d;
      cnt_q    <= cnt_d;
      load_q   <= load_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_d;

endmodule

// File: rtl/ym3438_timer_bank.sv
// Timer A / Timer B bank: c1 samples the register/tick inputs, the next c2
// commits them. Timer B counts prescaled ticks. Provides flags, IRQ, CSM key.
module ym3438_timer_bank
  import ym3438_timer_pkg::*;
#(
  parameter int TA_WIDTH    = 10,
  parameter int TB_WIDTH    = 8,
  parameter int TB_PRESCALE = 16,
  parameter int CSM_EN      = 1
) (
  input  logic                MCLK,
  input  logic                IC,
  input  logic                c1,
  input  logic                c2,
  input  logic                timer_ed,
  input  logic                ta_wr,
  input  logic [TA_WIDTH-1:0] ta_val,
  input  logic                tb_wr,
  input  logic [TB_WIDTH-1:0] tb_val,
  input  logic                ctrl_wr,
  input  logic [7:0]          ctrl,
  output logic                timer_a,
  output logic                timer_b,
  output logic                irq,
  output logic                csm_key,
  output logic [TA_WIDTH-1:0] ta_cnt,
  output logic [TB_WIDTH-1:0] tb_cnt
);

  localparam int PW = (TB_PRESCALE > 1) ? $clog2(TB_PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TB_PRESCALE - 1);

  // Sampled (c1) image of the inputs, pending until the next commit.
  logic                smp_vld_q, smp_vld_d;
  logic                smp_tick_q, smp_tick_d;
  logic                smp_ta_wr_q, smp_ta_wr_d;
  logic [TA_WIDTH-1:0] smp_ta_val_q, smp_ta_val_d;
  logic                smp_tb_wr_q, smp_tb_wr_d;
  logic [TB_WIDTH-1:0] smp_tb_val_q, smp_tb_val_d;
  logic                smp_ctrl_wr_q, smp_ctrl_wr_d;
  logic [7:0]          smp_ctrl_q, smp_ctrl_d;

  // Committed state.
  logic                en_a_q, en_a_d, en_b_q, en_b_d;
  logic [1:0]          mode_q, mode_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic                timer_a_q, timer_a_d, timer_b_q, timer_b_d;
  logic                irq_q, irq_d;
  logic                csm_q, csm_d;

  logic                commit_s, tick_s, tb_tick_s;
  logic                ovf_a_s, ovf_b_s, rst_a_s, rst_b_s;

  assign commit_s  = c2 & smp_vld_q;
  assign tick_s    = commit_s & smp_tick_q;
  assign tb_tick_s = tick_s & (presc_q == PRESC_LAST);
  assign rst_a_s   = commit_s & smp_ctrl_wr_q & smp_ctrl_q[CTRL_RST_A];
  assign rst_b_s   = commit_s & smp_ctrl_wr_q & smp_ctrl_q[CTRL_RST_B];

  // Sample stage: c1 captures inputs (last write wins), a commit consumes them.
  always_comb begin
    smp_vld_d     = smp_vld_q;
    smp_tick_d    = smp_tick_q;
    smp_ta_wr_d   = smp_ta_wr_q;
    smp_ta_val_d  = smp_ta_val_q;
    smp_tb_wr_d   = smp_tb_wr_q;
    smp_tb_val_d  = smp_tb_val_q;
    smp_ctrl_wr_d = smp_ctrl_wr_q;
    smp_ctrl_d    = smp_ctrl_q;
    if (c1) begin
      smp_vld_d  = 1'b1;
      smp_tick_d = timer_ed;
      if (ta_wr) begin
        smp_ta_wr_d  = 1'b1;
        smp_ta_val_d = ta_val;
      end else begin
        smp_ta_wr_d  = smp_ta_wr_q;
      end
      if (tb_wr) begin
        smp_tb_wr_d  = 1'b1;
        smp_tb_val_d = tb_val;
      end else begin
        smp_tb_wr_d  = smp_tb_wr_q;
      end
      if (ctrl_wr) begin
        smp_ctrl_wr_d = 1'b1;
        smp_ctrl_d    = ctrl;
      end else begin
        smp_ctrl_wr_d = smp_ctrl_wr_q;
      end
    end else if (commit_s) begin
      smp_vld_d     = 1'b0;
      smp_tick_d    = 1'b0;
      smp_ta_wr_d   = 1'b0;
      smp_tb_wr_d   = 1'b0;
      smp_ctrl_wr_d = 1'b0;
    end else begin
      smp_vld_d = smp_vld_q;
    end
  end

  // Commit stage: control bits, prescaler, flags, IRQ and CSM key.
  always_comb begin
    en_a_d    = en_a_q;
    en_b_d    = en_b_q;
    mode_d    = mode_q;
    presc_d   = presc_q;
    timer_a_d = timer_a_q;
    timer_b_d = timer_b_q;
    csm_d     = csm_q;
    if (commit_s && smp_ctrl_wr_q) begin
      en_a_d = smp_ctrl_q[CTRL_EN_A];
      en_b_d = smp_ctrl_q[CTRL_EN_B];
      mode_d = smp_ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO];
    end else begin
      mode_d = mode_q;
    end
    if (tick_s) begin
      if (tb_tick_s) begin
        presc_d = '0;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else begin
      presc_d = presc_q;
    end
    // An overflow setting the flag beats a simultaneous RST strobe.
    if (ovf_a_s && en_a_d) begin
      timer_a_d = 1'b1;
    end else if (rst_a_s) begin
      timer_a_d = 1'b0;
    end else begin
      timer_a_d = timer_a_q;
    end
    if (ovf_b_s && en_b_d) begin
      timer_b_d = 1'b1;
    end else if (rst_b_s) begin
      timer_b_d = 1'b0;
    end else begin
      timer_b_d = timer_b_q;
    end
    // CSM key lasts from an overflow until the next ticking commit.
    if (CSM_EN == 0) begin
      csm_d = 1'b0;
    end else if (tick_s) begin
      csm_d = ovf_a_s & is_csm(mode_d);
    end else begin
      csm_d = csm_q;
    end
    irq_d = timer_a_d | timer_b_d;
  end

  // State registers; IC clears everything including pending samples.
  always_ff @(posedge MCLK) begin
    if (IC) begin
      smp_vld_q     <= 1'b0;
      smp_tick_q    <= 1'b0;
      smp_ta_wr_q   <= 1'b0;
      smp_ta_val_q  <= '0;
      smp_tb_wr_q   <= 1'b0;
      smp_tb_val_q  <= '0;
      smp_ctrl_wr_q <= 1'b0;
      smp_ctrl_q    <= 8'h00;
      en_a_q        <= 1'b0;
      en_b_q        <= 1'b0;
      mode_q        <= 2'b00;
      presc_q       <= '0;
      timer_a_q     <= 1'b0;
      timer_b_q     <= 1'b0;
      irq_q         <= 1'b0;
      csm_q         <= 1'b0;
    end else begin
      smp_vld_q     <= smp_vld_d;
      smp_tick_q    <= smp_tick_d;
      smp_ta_wr_q   <= smp_ta_wr_d;
      smp_ta_val_q  <= smp_ta_val_d;
      smp_tb_wr_q   <= smp_tb_wr_d;
      smp_tb_val_q  <= smp_tb_val_d;
      smp_ctrl_wr_q <= smp_ctrl_wr_d;
      smp_ctrl_q    <= smp_ctrl_d;
      en_a_q        <= en_a_d;
      en_b_q        <= en_b_d;
      mode_q        <= mode_d;
      presc_q       <= presc_d;
      timer_a_q     <= timer_a_d;
      timer_b_q     <= timer_b_d;
      irq_q         <= irq_d;
      csm_q         <= csm_d;
    end
  end

  ym3438_timer_counter #(.WIDTH(TA_WIDTH)) u_timer_a (
    .clk     (MCLK),
    .rst     (IC),
    .commit  (commit_s),
    .tick    (tick_s),
    .load_wr (smp_ctrl_wr_q),
    .load_in (smp_ctrl_q[CTRL_LOAD_A]),
    .val_wr  (smp_ta_wr_q),
    .val     (smp_ta_val_q),
    .cnt     (ta_cnt),
    .ovf     (ovf_a_s)
  );

  ym3438_timer_counter #(.WIDTH(TB_WIDTH)) u_timer_b (
    .clk     (MCLK),
    .rst     (IC),
    .commit  (commit_s),
    .tick    (tb_tick_s),
    .load_wr (smp_ctrl_wr_q),
    .load_in (smp_ctrl_q[CTRL_LOAD_B]),
    .val_wr  (smp_tb_wr_q),
    .val     (smp_tb_val_q),
    .cnt     (tb_cnt),
    .ovf     (ovf_b_s)
  );

  assign timer_a = timer_a_q;
  assign timer_b = timer_b_q;
  assign irq     = irq_q;
  assign csm_key = csm_q;

endmodule

// File: doc/ym3438_timer_bank.md
# ym3438_timer_bank

Parametrised Timer A / Timer B unit for the OPN2 core. It replaces the constant `timer_a(0)` / `timer_b(0)` ties on `ym3438_io` with real flags, and provides the IRQ request and the CSM (channel-3 composite sine mode) key-on pulse. It counts sample-frame ticks from `ym3438_fsm` (`fsm_timer_ed`) and takes its register writes from `ym3438_reg_ctrl` (regs 0x24–0x27). Widths and the Timer B prescale are generalised beyond the fixed 10/8/÷16 silicon values.

## Interface
Parameters:
- `TA_WIDTH`, default 10: Timer A counter/reload width.
- `TB_WIDTH`, default 8: Timer B counter/reload width.
- `TB_PRESCALE`, default 16: Timer B tick divider. Must be a power of two and ≥ 1.
- `CSM_EN`, default 1: 0 removes the CSM logic; `csm_key` is then tied 0.

Ports:
- `MCLK` in 1: the single clock. All state changes on its rising edge.
- `IC` in 1: reset, synchronous and active-high.
- `c1` in 1: phase-1 enable (sample phase). Never asserted in the same cycle as `c2`.
- `c2` in 1: phase-2 enable (commit phase).
- `timer_ed` in 1: sample-frame tick, qualified by `c1`.
- `ta_wr` in 1: write strobe for the Timer A reload value.
- `ta_val` in `TA_WIDTH`: Timer A reload value.
- `tb_wr` in 1: write strobe for the Timer B reload value.
- `tb_val` in `TB_WIDTH`: Timer B reload value.
- `ctrl_wr` in 1: write strobe for the reg 0x27 image.
- `ctrl` in 8: reg 0x27 image.
- `timer_a` out 1: Timer A overflow flag.
- `timer_b` out 1: Timer B overflow flag.
- `irq` out 1: `timer_a | timer_b`.
- `csm_key` out 1: CSM key-on request.
- `ta_cnt` out `TA_WIDTH`: live Timer A count.
- `tb_cnt` out `TB_WIDTH`: live Timer B count.

## Operation
ctrl bits:
- [0] `LOAD_A`, [1] `LOAD_B`: stored; each gates its counter.
- [2] `EN_A`, [3] `EN_B`: stored; each gates flag setting.
- [4] `RST_A`, [5] `RST_B`: strobes, not stored; a 1 clears the corresponding flag.
- [7:6] `MODE`: stored; CSM is active when `MODE == 2'b10`.

Counter rules (A shown; B is identical on the prescaled tick):
- `LOAD_A` 0→1 transition: count ← reload register (the value held before this write commits).
- `LOAD_A` = 1 and a tick: if count is all-ones, overflow and count ← reload; otherwise count + 1.
- `LOAD_A` = 0: count frozen. No overflow.
- Reload write while running: affects only the next reload. The current count is untouched.
- Reload and tick in the same frame: the reload wins and no increment happens.

Prescaler:
- Free-running modulo-`TB_PRESCALE` count of ticks. Runs regardless of `LOAD_B`.
- The B tick occurs when the prescaler wraps to 0.
- With `TB_PRESCALE` = 1, every tick is a B tick.

Flags:
- An overflow with EN=1 sets the flag. An overflow with EN=0 leaves the flag unchanged.
- Set and `RST` in the same commit: set wins.
- Flags are sticky until cleared by `RST_x` or `IC`.

CSM:
- A Timer A overflow while CSM is active raises `csm_key`, independent of `EN_A`.
- `csm_key` is held until the next commit that carries a tick, then drops, unless a new overflow occurs on that commit.

## Timing
- Inputs (`timer_ed`, `*_wr`, `*_val`, `ctrl`) are sampled on a `c1` cycle and committed on the next `c2` cycle. Outputs change in the cycle after that `c2` edge.
- Write-to-effect latency: one `c1`→`c2` phase pair.
- Tick-to-flag latency: the same phase pair. No further pipelining.
- Multiple writes between two `c2` cycles: the last sampled `c1` value wins.
- Reset on `IC`, on any `MCLK` edge regardless of `c1`/`c2`:
  - all counters, reload registers and the prescaler are 0;
  - ctrl state is 0;
  - `timer_a`, `timer_b`, `irq` and `csm_key` are 0.
- `IC` asserted mid-count discards the pending sampled inputs. After `IC` is released, the first `c1` sample is treated as fresh.
- A `c2` cycle with no preceding `c1` since the last commit: no state change.

## Structure
- Package `ym3438_timer_pkg` holds:
  - ctrl bit-index constants `CTRL_LOAD_A` … `CTRL_RST_B`, plus `CTRL_MODE_LO` and `CTRL_MODE_HI`;
  - mode enum: NORMAL / CSM / 3CH (values 00 / 10 / x1).
- Sub-module `ym3438_timer_counter #(WIDTH)` contains:
  - reload register and count;
  - load-edge detect;
  - the overflow output.
- It is instantiated twice. Timer B is fed by the prescaler, which lives in the parent.

## Test plan
- Timer A overflow:
  - Stimulus: `IC`; then `ta_val` = 0x3FE; then `ctrl` = 0x05; then 2 ticks.
  - Response: `ta_cnt` reads 0x3FE → 0x3FF → 0x3FE; `timer_a` = 1 and `irq` = 1 after the 2nd tick's commit.
- Timer B prescale:
  - Stimulus: `tb_val` = 0xFF, `ctrl` = 0x0A.
  - Response: `timer_b` rises after exactly 16 ticks (prescaler started at 0). With `TB_PRESCALE` = 4, it rises after 4 ticks.
- Flag set vs. clear:
  - Stimulus: `ctrl` = 0x15 written so that it commits on the overflow commit.
  - Response: `timer_a` stays 1. A later `ctrl` = 0x15 write clears it.
- EN gating and CSM:
  - Stimulus: `ctrl` = 0x81 with `ta_val` = 0x3FF.
  - Response: every tick overflows; `timer_a` stays 0; `csm_key` is 1 for one frame per overflow. With `CSM_EN` = 0, `csm_key` is always 0.
- Freeze and reload:
  - Stimulus: clear `LOAD_A` mid-count.
  - Response: `ta_cnt` holds. Setting `LOAD_A` again reloads the `ta_val` written in between; a tick in that same frame does not increment.
- Reset mid-operation:
  - Stimulus: `IC` pulse with flags set and counters running.
  - Response: all outputs 0 the next cycle. A write on the first `c1` after release takes effect normally.
